// File: rtl/benes_pkg.sv
// Shared constants and types for the 8x8 Benes network configuration path.
package benes_pkg;

    localparam int NUM_STAGES   = 5;
    localparam int SW_PER_STAGE = 4;
    localparam int IDX_W        = 3;

    typedef logic [SW_PER_STAGE-1:0] sw_word_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        PEND
    } cfg_state_t;

endpackage

// File: rtl/benes_cfg_loader.sv
// Streams one control word per stage into a shadow frame.
// A complete frame is transferred atomically to switch_set on commit.
module benes_cfg_loader
    import benes_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      cfg_valid,
    output logic                                      cfg_ready,
    input  logic [SW_PER_STAGE-1:0]                   cfg_data,
    input  logic                                      cfg_last,
    input  logic                                      commit_en,
    output logic [NUM_STAGES-1:0][SW_PER_STAGE-1:0]   switch_set,
    output logic                                      cfg_pending,
    output logic                                      cfg_applied,
    output logic                                      cfg_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    cfg_state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic err_q, err_d;
    logic applied_q;
    logic run_q;
    logic accept;
    logic commit;
    logic shadow_we;
    sw_word_t shadow_q [NUM_STAGES];
    logic [NUM_STAGES-1:0][SW_PER_STAGE-1:0] switch_set_q;

    assign accept = cfg_valid && cfg_ready;

    // run_q keeps ready low throughout reset without a path from rst_n.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            err_q        <= 1'b0;
            applied_q    <= 1'b0;
            run_q        <= 1'b0;
            switch_set_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            applied_q <= commit;
            run_q     <= 1'b1;
            if (commit) begin
                for (int k = 0; k < NUM_STAGES; k++) begin
                    switch_set_q[k] <= shadow_q[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (shadow_we) begin
            shadow_q[idx_q] <= cfg_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_d     = 1'b0;
        commit    = 1'b0;
        shadow_we = 1'b0;
        unique case (state_q)
            IDLE: begin
                idx_d = '0;
                if (accept) begin
                    shadow_we = 1'b1;
                    if (cfg_last && NUM_STAGES > 1) begin
                        err_d = 1'b1;
                    end else begin
                        idx_d   = IDX_W'(1);
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    shadow_we = 1'b1;
                    if (idx_q < LAST_IDX) begin
                        if (cfg_last) begin
                            err_d   = 1'b1;
                            idx_d   = '0;
                            state_d = IDLE;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        idx_d   = '0;
                        state_d = cfg_last ? PEND : DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accept && cfg_last) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            PEND: begin
                if (commit_en) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready   = 1'b0;
        cfg_pending = 1'b0;
        if (run_q) begin
            cfg_ready   = (state_q != PEND);
            cfg_pending = (state_q == PEND);
        end
    end

    assign switch_set  = switch_set_q;
    assign cfg_applied = applied_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_benes_cfg_loader.sv
// Directed bench for benes_cfg_loader: nominal, held commit, short/long frames,
// idle gaps and reset in mid-frame and in the pending state.
module tb_benes_cfg_loader;
    import benes_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic cfg_valid;
    logic cfg_ready;
    logic [SW_PER_STAGE-1:0] cfg_data;
    logic cfg_last;
    logic commit_en;
    logic [NUM_STAGES-1:0][SW_PER_STAGE-1:0] switch_set;
    logic cfg_pending;
    logic cfg_applied;
    logic cfg_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    benes_cfg_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .cfg_last   (cfg_last),
        .commit_en  (commit_en),
        .switch_set (switch_set),
        .cfg_pending(cfg_pending),
        .cfg_applied(cfg_applied),
        .cfg_err    (cfg_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one word and hold it until accepted (bounded).
    task automatic send_word(input logic [3:0] data, input logic last);
        logic accepted;
        accepted  = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = data;
        cfg_last  = last;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (cfg_ready) accepted = 1'b1;
            step();
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        chk("accept", {31'd0, accepted}, 32'd1);
        $display("word %h last %0b accepted %0b", data, last, accepted);
    endtask

    task automatic send_frame(input logic [19:0] f, input int gaps);
        for (int s = 0; s < NUM_STAGES; s++) begin
            logic [19:0] tmp;
            tmp = f >> (4 * s);
            send_word(tmp[3:0], s == NUM_STAGES - 1);
            if (gaps != 0 && s != NUM_STAGES - 1) begin
                repeat ($urandom_range(1, 3)) step();
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0; commit_en = 1'b0;
        repeat (3) step();
        chk("rst_ready", {31'd0, cfg_ready}, 32'd0);
        chk("rst_pending", {31'd0, cfg_pending}, 32'd0);
        chk("rst_applied", {31'd0, cfg_applied}, 32'd0);
        chk("rst_err", {31'd0, cfg_err}, 32'd0);
        chk("rst_switch", 32'(switch_set), 32'h0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rel", {31'd0, cfg_ready}, 32'd1);

        // Nominal frame, stage0 first: 1,2,4,8,F.
        commit_en = 1'b1;
        send_frame(20'hF8421, 0);
        chk("nom_pending", {31'd0, cfg_pending}, 32'd1);
        chk("nom_ready_lo", {31'd0, cfg_ready}, 32'd0);
        chk("nom_sw_old", 32'(switch_set), 32'h0);
        step();
        chk("nom_sw", 32'(switch_set), 32'hF8421);
        chk("nom_applied", {31'd0, cfg_applied}, 32'd1);
        chk("nom_pend_lo", {31'd0, cfg_pending}, 32'd0);
        chk("nom_ready", {31'd0, cfg_ready}, 32'd1);
        step();
        chk("nom_applied_lo", {31'd0, cfg_applied}, 32'd0);
        $display("nominal switch_set %h", switch_set);

        // Held commit: 5,6,7,9,3 waits 10 cycles.
        commit_en = 1'b0;
        send_frame(20'h39765, 0);
        for (int c = 0; c < 10; c++) begin
            chk("hold_ready", {31'd0, cfg_ready}, 32'd0);
            chk("hold_sw", 32'(switch_set), 32'hF8421);
            if (c != 9) step();
        end
        commit_en = 1'b1;
        step();
        chk("hold_sw_new", 32'(switch_set), 32'h39765);
        chk("hold_applied", {31'd0, cfg_applied}, 32'd1);
        $display("held commit switch_set %h", switch_set);

        // Short frame of 3 words.
        send_word(4'h1, 1'b0);
        send_word(4'h2, 1'b0);
        send_word(4'h3, 1'b1);
        chk("short_err", {31'd0, cfg_err}, 32'd1);
        chk("short_sw", 32'(switch_set), 32'h39765);
        chk("short_pend", {31'd0, cfg_pending}, 32'd0);
        step();
        chk("short_err_lo", {31'd0, cfg_err}, 32'd0);
        send_frame(20'h15A0C, 0);
        step();
        chk("after_short_sw", 32'(switch_set), 32'h15A0C);
        chk("after_short_applied", {31'd0, cfg_applied}, 32'd1);
        $display("short frame then switch_set %h", switch_set);

        // Long frame of 7 words.
        for (int w = 0; w < 6; w++) begin
            send_word(4'(w + 1), 1'b0);
            chk("long_no_err", {31'd0, cfg_err}, 32'd0);
        end
        send_word(4'h7, 1'b1);
        chk("long_err", {31'd0, cfg_err}, 32'd1);
        chk("long_pend", {31'd0, cfg_pending}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("long_no_apply", {31'd0, cfg_applied}, 32'd0);
            chk("long_sw", 32'(switch_set), 32'h15A0C);
        end
        $display("long frame switch_set %h", switch_set);

        // Gaps between words: 2,4,6,8,A.
        send_frame(20'hA8642, 1);
        chk("gap_pending", {31'd0, cfg_pending}, 32'd1);
        step();
        chk("gap_sw", 32'(switch_set), 32'hA8642);
        $display("gapped frame switch_set %h", switch_set);

        // Reset after two words.
        send_word(4'hE, 1'b0);
        send_word(4'hD, 1'b0);
        rst_n = 1'b0;
        step();
        chk("rst_mid_sw", 32'(switch_set), 32'h0);
        chk("rst_mid_err", {31'd0, cfg_err}, 32'd0);
        chk("rst_mid_ready", {31'd0, cfg_ready}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_mid_ready_rel", {31'd0, cfg_ready}, 32'd1);
        chk("rst_mid_err_rel", {31'd0, cfg_err}, 32'd0);
        send_frame(20'h12345, 0);
        step();
        chk("rst_mid_next_sw", 32'(switch_set), 32'h12345);
        $display("after mid-frame reset switch_set %h", switch_set);

        // Reset while pending.
        commit_en = 1'b0;
        send_frame(20'hFFFFF, 0);
        chk("rst_pend_pending", {31'd0, cfg_pending}, 32'd1);
        rst_n = 1'b0;
        step();
        chk("rst_pend_sw", 32'(switch_set), 32'h0);
        chk("rst_pend_pend_lo", {31'd0, cfg_pending}, 32'd0);
        chk("rst_pend_err", {31'd0, cfg_err}, 32'd0);
        rst_n = 1'b1;
        commit_en = 1'b1;
        step();
        chk("rst_pend_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst_pend_no_apply", {31'd0, cfg_applied}, 32'd0);
        send_frame(20'h3C96A, 0);
        step();
        chk("rst_pend_next_sw", 32'(switch_set), 32'h3C96A);
        chk("rst_pend_next_applied", {31'd0, cfg_applied}, 32'd1);
        $display("after pending reset switch_set %h", switch_set);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
